fp_div_mant_iter: RTL and testbench



---
 rtl/fp_div_pkg.sv | 24 ++
 rtl/fp_div_step.sv | 20 ++
 rtl/fp_div_mant_iter.sv | 142 ++++++++++++++
 tb/tb_fp_div_mant_iter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the FP32 significand divider.
// Optional early termination is selected with FP_DIV_EARLY_TERM_EN.
package fp_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int FP_EXP_WIDTH  = 8;
    localparam int FP_MANT_WIDTH = 23;
    localparam int EXP_BIAS      = 127;
    localparam int SIG_WIDTH     = FP_MANT_WIDTH + 1;
    localparam int ITER_COUNT    = 24;

    // Largest and smallest biased exponents that are still normal numbers.
    localparam int EXP_UDF_LIMIT = 1;

    function automatic int exp_ovf_limit(input int exp_width);
        return (1 << exp_width) - 2;
    endfunction

endpackage

// File: rtl/fp_div_step.sv
// One restoring-division iteration: compare, conditionally subtract, shift left.
module fp_div_step #(
    parameter int W = 24
) (
    input  logic [W:0]   r_i,
    input  logic [W-1:0] b_i,
    output logic [W:0]   r_o,
    output logic         q_o
);

    logic [W:0] diff;

    // The remainder stays below 2*B, so the shifted result never loses a set bit.
    always_comb begin
        q_o  = (r_i >= {1'b0, b_i});
        diff = q_o ? (r_i - {1'b0, b_i}) : r_i;
        r_o  = diff << 1;
    end

endmodule

// File: rtl/fp_div_mant_iter.sv
// Iterative radix-2 restoring divider for FP32 significands with exponent and flags.
// Defining FP_DIV_EARLY_TERM_EN ends the iteration as soon as the remainder reaches zero.
module fp_div_mant_iter
    import fp_div_pkg::*;
#(
    parameter int EXP_WIDTH  = FP_EXP_WIDTH,
    parameter int MANT_WIDTH = FP_MANT_WIDTH,
    parameter int EXP_BIAS   = fp_div_pkg::EXP_BIAS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_Start,
    input  logic [EXP_WIDTH-1:0]  in_ExpA,
    input  logic [EXP_WIDTH-1:0]  in_ExpB,
    input  logic [MANT_WIDTH:0]   in_MantA,
    input  logic [MANT_WIDTH:0]   in_MantB,
    output logic                  out_Busy,
    output logic                  out_Valid,
    output logic [EXP_WIDTH-1:0]  out_Exp,
    output logic [MANT_WIDTH:0]   out_Mant,
    output logic                  out_Sticky,
    output logic                  out_ExpOvf,
    output logic                  out_ExpUdf,
    output logic                  out_DivZero
);

    localparam int SW = MANT_WIDTH + 1;
    localparam int CW = $clog2(SW);
    localparam int XW = EXP_WIDTH + 2;

    state_e                state_q;
    logic [SW-1:0]         b_q;
    logic [SW-1:0]         q_q;
    logic [SW-1:0]         q_d;
    logic [SW:0]           r_q;
    logic [SW:0]           r_step;
    logic                  q_bit;
    logic [CW-1:0]         cnt_q;
    logic [EXP_WIDTH-1:0]  exp_q;
    logic                  ovf_q;
    logic                  udf_q;
    logic signed [XW-1:0]  exp_calc;
    logic                  exp_ovf;
    logic                  exp_udf;
    logic                  last_step;

    fp_div_step #(.W(SW)) u_step (
        .r_i (r_q),
        .b_i (b_q),
        .r_o (r_step),
        .q_o (q_bit)
    );

    // Two guard bits keep the unbounded exponent exact for the flag compares.
    always_comb begin
        exp_calc = $signed({2'b00, in_ExpA}) - $signed({2'b00, in_ExpB}) + $signed(XW'(EXP_BIAS));
        exp_ovf  = (int'(exp_calc) > exp_ovf_limit(EXP_WIDTH));
        exp_udf  = (int'(exp_calc) < EXP_UDF_LIMIT);
    end

    always_comb begin
        q_d        = q_q;
        q_d[cnt_q] = q_bit;
`ifdef FP_DIV_EARLY_TERM_EN
        last_step  = (cnt_q == '0) || (r_step == '0);
`else
        last_step  = (cnt_q == '0);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            b_q         <= '0;
            q_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            exp_q       <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            out_Busy    <= 1'b0;
            out_Valid   <= 1'b0;
            out_Exp     <= '0;
            out_Mant    <= '0;
            out_Sticky  <= 1'b0;
            out_ExpOvf  <= 1'b0;
            out_ExpUdf  <= 1'b0;
            out_DivZero <= 1'b0;
        end else begin
            out_Valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_Start) begin
                        b_q   <= in_MantB;
                        r_q   <= {1'b0, in_MantA};
                        q_q   <= '0;
                        cnt_q <= CW'(SW - 1);
                        exp_q <= exp_calc[EXP_WIDTH-1:0];
                        ovf_q <= exp_ovf;
                        udf_q <= exp_udf;
                        if (in_MantB == '0) begin
                            state_q     <= DONE;
                            out_Valid   <= 1'b1;
                            out_DivZero <= 1'b1;
                            out_Mant    <= '1;
                            out_Sticky  <= 1'b0;
                            out_Exp     <= exp_calc[EXP_WIDTH-1:0];
                            out_ExpOvf  <= exp_ovf;
                            out_ExpUdf  <= exp_udf;
                        end else begin
                            state_q     <= RUN;
                            out_Busy    <= 1'b1;
                            out_DivZero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    r_q   <= r_step;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (last_step) begin
                        state_q    <= DONE;
                        out_Busy   <= 1'b0;
                        out_Valid  <= 1'b1;
                        out_Mant   <= q_d;
                        out_Sticky <= (r_step != '0);
                        out_Exp    <= exp_q;
                        out_ExpOvf <= ovf_q;
                        out_ExpUdf <= udf_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_mant_iter.sv
// Randomised and directed bench for fp_div_mant_iter against an arithmetic reference model.
module tb_fp_div_mant_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_Start;
    logic [7:0]  in_ExpA;
    logic [7:0]  in_ExpB;
    logic [23:0] in_MantA;
    logic [23:0] in_MantB;
    logic        out_Busy;
    logic        out_Valid;
    logic [7:0]  out_Exp;
    logic [23:0] out_Mant;
    logic        out_Sticky;
    logic        out_ExpOvf;
    logic        out_ExpUdf;
    logic        out_DivZero;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected record: {divzero, ovf, udf, sticky, exp[7:0], mant[23:0]}
    logic [35:0] exp_q[$];

    fp_div_mant_iter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_Start    (in_Start),
        .in_ExpA     (in_ExpA),
        .in_ExpB     (in_ExpB),
        .in_MantA    (in_MantA),
        .in_MantB    (in_MantB),
        .out_Busy    (out_Busy),
        .out_Valid   (out_Valid),
        .out_Exp     (out_Exp),
        .out_Mant    (out_Mant),
        .out_Sticky  (out_Sticky),
        .out_ExpOvf  (out_ExpOvf),
        .out_ExpUdf  (out_ExpUdf),
        .out_DivZero (out_DivZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [35:0] model(input logic [7:0] ea, input logic [7:0] eb,
                                          input logic [23:0] ma, input logic [23:0] mb);
        int          e;
        logic [7:0]  e8;
        longint      num;
        logic [23:0] mant;
        logic        st;
        logic        dz;
        e  = int'(ea) - int'(eb) + 127;
        e8 = e[7:0];
        if (mb == 24'd0) begin
            mant = 24'hFFFFFF;
            st   = 1'b0;
            dz   = 1'b1;
        end else begin
            num  = longint'(ma) << 23;
            mant = 24'(num / longint'(mb));
            st   = (num % longint'(mb)) != 0;
            dz   = 1'b0;
        end
        return {dz, (e > 254), (e < 1), st, e8, mant};
    endfunction

    // Cycle (counted from accept = 0) on which the result strobe is visible.
    function automatic int model_lat(input logic [23:0] ma, input logic [23:0] mb);
        if (mb == 24'd0) return 1;
`ifdef FP_DIV_EARLY_TERM_EN
        for (int k = 1; k <= 24; k++) begin
            if (((longint'(ma) << (k - 1)) % longint'(mb)) == 0) return k + 1;
        end
`endif
        return 25;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_Valid), 32'd0);
        check({tag, "_busy"}, 32'(out_Busy), 32'd0);
        check({tag, "_mant"}, 32'(out_Mant), 32'd0);
        check({tag, "_exp"}, 32'(out_Exp), 32'd0);
        check({tag, "_flags"}, 32'({out_Sticky, out_ExpOvf, out_ExpUdf, out_DivZero}), 32'd0);
    endtask

    // Issues one division at the current negedge; p1/p2 inject ignored start pulses sampled on those edges.
    task automatic do_div(input logic [7:0] ea, input logic [7:0] eb,
                          input logic [23:0] ma, input logic [23:0] mb,
                          input int p1, input int p2,
                          output int acc_wait, output logic [35:0] res);
        int          lat_exp;
        int          k;
        logic        accepted;
        logic [35:0] e;
        exp_q.push_back(model(ea, eb, ma, mb));
        lat_exp  = model_lat(ma, mb);
        in_ExpA  = ea;
        in_ExpB  = eb;
        in_MantA = ma;
        in_MantB = mb;
        in_Start = 1'b1;
        acc_wait = 0;
        accepted = 1'b0;
        while (!accepted && acc_wait < 5) begin
            @(posedge clk);
            @(negedge clk);
            acc_wait++;
            if (out_Busy || out_Valid) accepted = 1'b1;
        end
        in_Start = 1'b0;
        e = exp_q.pop_front();
        res = e;
        if (!accepted) begin
            check("accept", 32'(accepted), 32'd1);
            return;
        end
        k = 0;
        while (!out_Valid && k < 40) begin
            if (k == p1 - 1 || k == p2 - 1) begin
                in_Start = 1'b1;
                in_MantA = 24'($urandom);
                in_MantB = 24'd0;
            end else begin
                in_Start = 1'b0;
            end
            if (k == 12 && lat_exp > 14) check("busy_run", 32'(out_Busy), 32'd1);
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        in_Start = 1'b0;
        if (!out_Valid) begin
            check("valid_timeout", 32'(out_Valid), 32'd1);
            return;
        end
        check("latency", 32'(k + 1), 32'(lat_exp));
        check("mant", 32'(out_Mant), 32'(e[23:0]));
        check("exp", 32'(out_Exp), 32'(e[31:24]));
        check("sticky", 32'(out_Sticky), 32'(e[32]));
        check("udf", 32'(out_ExpUdf), 32'(e[33]));
        check("ovf", 32'(out_ExpOvf), 32'(e[34]));
        check("divzero", 32'(out_DivZero), 32'(e[35]));
        check("busy_at_valid", 32'(out_Busy), 32'd0);
    endtask

    task automatic watch_quiet(input string tag, input int n);
        int seen = 0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            if (out_Valid) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int          w;
        logic [35:0] r;
        logic [23:0] ma;
        logic [23:0] mb;

        rst_n    = 1'b0;
        in_Start = 1'b0;
        in_ExpA  = '0;
        in_ExpB  = '0;
        in_MantA = '0;
        in_MantB = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        do_div(8'd127, 8'd127, 24'h800000, 24'h800000, -9, -9, w, r);
        @(negedge clk);
        check("strobe_one_cycle", 32'(out_Valid), 32'd0);
        check("mant_hold", 32'(out_Mant), 32'(r[23:0]));
        do_div(8'd127, 8'd127, 24'h800000, 24'hC00000, -9, -9, w, r);
        do_div(8'd130, 8'd127, 24'hC00000, 24'h800000, -9, -9, w, r);
        do_div(8'd254, 8'd1,   24'hA00000, 24'hE00000, -9, -9, w, r);
        do_div(8'd1,   8'd200, 24'hF00000, 24'h900000, -9, -9, w, r);
        do_div(8'd127, 8'd127, 24'h812345, 24'd0, -9, -9, w, r);
        do_div(8'd100, 8'd90,  24'hB00000, 24'h880000, -9, -9, w, r);

        // Starts during RUN are dropped; only the original division completes.
        do_div(8'd127, 8'd127, 24'hFFFFFF, 24'h800001, 5, 24, w, r);
        watch_quiet("single_valid", 30);

        // A start held from the strobe cycle is taken on the following cycle.
        do_div(8'd140, 8'd120, 24'h9ABCDE, 24'hC34567, -9, -9, w, r);
        do_div(8'd120, 8'd140, 24'hFEDCBA, 24'h812345, -9, -9, w, r);
        check("b2b_accept_wait", 32'(w), 32'd2);

        @(negedge clk);
        in_ExpA  = 8'd127;
        in_ExpB  = 8'd127;
        in_MantA = 24'hC00000;
        in_MantB = 24'hA00000;
        in_Start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_Start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        watch_quiet("no_valid_after_reset", 30);

        for (int i = 0; i < 40; i++) begin
            ma = {1'b1, 23'($urandom)};
            mb = {1'b1, 23'($urandom)};
            if (i % 8 == 3) mb = 24'h800000;
            if (i % 8 == 5) ma = mb;
            if (i % 13 == 7) mb = 24'd0;
            do_div(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), ma, mb, -9, -9, w, r);
            if (($urandom_range(0, 1)) == 1) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
